// File: rtl/fpr_wb.sv
// FP writeback stage: 32x64 FP register file with NaN-boxing, same-cycle bypass,
// fflags/frm CSR state and a per-register busy scoreboard for RAW/WAW stalls.
module fpr_wb #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] data_rd,
   input  logic            fgpr_write,
   input  logic [4:0]      fd_index,
   input  logic            valid,
   input  logic            exception,
   input  logic [3:0]      size,
   input  logic [4:0]      fflags_in,
   input  logic            wb_hold,
   input  logic [4:0]      rs1_index,
   input  logic [4:0]      rs2_index,
   input  logic [4:0]      rs3_index,
   input  logic            rs1_use,
   input  logic            rs2_use,
   input  logic            rs3_use,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] rs3_data,
   input  logic            issue_valid,
   input  logic [4:0]      issue_fd,
   input  logic            flush,
   output logic            raw_stall,
   input  logic            csr_fflags_we,
   input  logic            csr_frm_we,
   input  logic [7:0]      csr_wdata,
   output logic [4:0]      fflags,
   output logic [2:0]      frm,
   output logic            commit
);

   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_busy;
   logic [4:0]      r_fflags;
   logic [2:0]      r_frm;
   logic            r_commit;

   logic            w_cm;
   logic            w_we;
   logic            w_exc_clr;
   logic [XLEN-1:0] w_wdata;
   logic [4:0]      w_rs_idx  [3];
   logic            w_rs_use  [3];
   logic [XLEN-1:0] w_rs_data [3];
   logic            w_stall;
   logic            w_waw;

   assign w_cm      = valid & ~exception & ~wb_hold;
   assign w_we      = w_cm & fgpr_write;
   assign w_exc_clr = valid & exception & fgpr_write & ~wb_hold;
   assign w_wdata   = (size == 4'b0100) ? {{(XLEN-32){1'b1}}, data_rd[31:0]} : data_rd;

   assign w_rs_idx = '{rs1_index, rs2_index, rs3_index};
   assign w_rs_use = '{rs1_use, rs2_use, rs3_use};

   // A register written this cycle is bypassed, so it neither stalls nor reads stale.
   always_comb begin
      w_stall = 1'b0;
      for (int unsigned n = 0; n < 3; n++) begin
         if (w_we && (fd_index == w_rs_idx[n])) begin
            w_rs_data[n] = w_wdata;
         end else begin
            w_rs_data[n] = r_regs[w_rs_idx[n]];
            if (w_rs_use[n] && r_busy[w_rs_idx[n]]) w_stall = 1'b1;
         end
         if (!rst) w_rs_data[n] = '0;
      end
      w_waw = issue_valid & r_busy[issue_fd] & ~(w_we & (fd_index == issue_fd));
   end

   assign rs1_data  = w_rs_data[0];
   assign rs2_data  = w_rs_data[1];
   assign rs3_data  = w_rs_data[2];
   assign raw_stall = w_stall | w_waw;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (w_we) begin
         r_regs[fd_index] <= w_wdata;
      end
   end

   // Set beats clear on the same index; flush beats both.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
      end else if (flush) begin
         r_busy <= '0;
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (issue_valid && !raw_stall && (issue_fd == 5'(i)))
               r_busy[i] <= 1'b1;
            else if ((w_we || w_exc_clr) && (fd_index == 5'(i)))
               r_busy[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fflags <= '0;
         r_frm    <= '0;
         r_commit <= 1'b0;
      end else begin
         if (csr_fflags_we)
            r_fflags <= csr_wdata[4:0];
         else if (w_cm)
            r_fflags <= r_fflags | fflags_in;
         if (csr_frm_we) r_frm <= csr_wdata[7:5];
         r_commit <= w_cm;
      end
   end

   assign fflags = r_fflags;
   assign frm    = r_frm;
   assign commit = r_commit;

endmodule
